uart_tx_param: RTL

Parametrised, runtime-configurable UART transmitter and successor to the fixed 8N1 transmitter. Adds valid/ready input handshake with a one-entry holding register, which allows back-to-back frames with no idle gap. Also adds runtime baud divisor, parity (none/even/odd) and 1 or 2 stop bits. Sits between a byte source (FIFO or command engine) and the board TX pin; clocked directly by dclk, with no derived clocks.

---
 rtl/uart_tx_param.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Runtime-configurable UART transmitter. A one-entry holding register sits in
// front of the shift stage so a new word can be accepted while the previous
// frame is still on the line, giving back-to-back frames with no idle gap.
// Baud divisor, parity mode and stop-bit count are captured together with the
// data word, so a frame always goes out with the settings it was accepted with.
//
// Parameters
//   WIDTH        data bits per frame (5..9)
//   DIV_W        width of the runtime baud divisor
//   DEFAULT_DIV  divisor value held by the shift stage after reset
//
// Ports
//   dclk        in   1      clock
//   i_reset     in   1      synchronous, active-high reset
//   i_data      in   WIDTH  payload, LSB transmitted first
//   i_valid     in   1      source has a word to send
//   o_ready     out  1      holding register empty; transfer on i_valid && o_ready
//   i_divisor   in   DIV_W  dclk cycles per bit (values below 2 act as 2)
//   i_parity    in   2      00 none, 01 even, 10 odd, 11 none
//   i_two_stop  in   1      1 = two stop bits
//   o_tx        out  1      registered serial line, idle high
//   o_busy      out  1      frame in progress (START..STOP2)
//   o_done      out  1      one-cycle pulse in the last cycle of each frame
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int WIDTH       = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 100
) (
    input  logic             dclk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic [1:0]       i_parity,
    input  logic             i_two_stop,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int               BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    // Holding register (word + the configuration it travels with)
    logic [WIDTH-1:0] r_hold_data;
    logic [DIV_W-1:0] r_hold_div;
    logic [1:0]       r_hold_par;
    logic             r_hold_two;
    logic             r_hold_full;

    // Shift stage
    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_par_en;
    logic             r_par_bit;
    logic             r_two_stop;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic [DIV_W-1:0] w_div_eff;
    logic             w_bit_end;
    logic             w_done_next;
    logic             w_last_stop;
    logic             w_frame_end;
    logic             w_load;
    logic             w_hold_par_en;
    logic             w_hold_par_bit;

    // o_ready comes straight from a flop, so the handshake never has a
    // combinational path from i_valid back to the source.
    assign o_ready  = ~r_hold_full;
    assign w_accept = i_valid & ~r_hold_full;

    // Divisors of 0 and 1 cannot produce a distinct done-cycle inside a bit,
    // so the effective minimum is 2.
    assign w_div_eff = (i_divisor < DIV_MIN) ? DIV_MIN : i_divisor;

    // Bit timing: the counter runs 0..D-1 within every bit.
    assign w_bit_end   = (r_baud_cnt == r_div - DIV_ONE);
    assign w_done_next = (r_baud_cnt == r_div - DIV_MIN);
    assign w_last_stop = (r_state == S_STOP2) ||
                         ((r_state == S_STOP1) && !r_two_stop);
    assign w_frame_end = w_bit_end && w_last_stop;

    // The holding register drains into the shifter either from IDLE or on the
    // final edge of a frame, which is what removes the inter-frame gap.
    assign w_load = r_hold_full && ((r_state == S_IDLE) || w_frame_end);

    assign w_hold_par_en  = (r_hold_par == 2'b01) || (r_hold_par == 2'b10);
    assign w_hold_par_bit = (^r_hold_data) ^ (r_hold_par == 2'b10);

    // NOTE: payload registers carry no reset; r_hold_full alone says whether
    // their contents mean anything, so resetting them would only add fan-out.
    always_ff @(posedge dclk) begin
        if (w_accept) begin
            r_hold_data <= i_data;
            r_hold_div  <= w_div_eff;
            r_hold_par  <= i_parity;
            r_hold_two  <= i_two_stop;
        end
    end

    // NOTE: all state below updates with non-blocking assignments so every
    // right-hand side sees the pre-edge values, independent of statement order.
    always_ff @(posedge dclk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_div       <= DIV_W'(DEFAULT_DIV);
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_two_stop  <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Raised one edge early so the pulse lands on the final cycle.
            r_done <= w_last_stop && w_done_next;

            if (w_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_state    <= S_START;
                r_shift    <= r_hold_data;
                r_div      <= r_hold_div;
                r_par_en   <= w_hold_par_en;
                r_par_bit  <= w_hold_par_bit;
                r_two_stop <= r_hold_two;
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_tx   <= 1'b1;
                r_busy <= 1'b0;
            end else if (!w_bit_end) begin
                r_baud_cnt <= r_baud_cnt + DIV_ONE;
            end else begin
                r_baud_cnt <= '0;
                unique case (r_state)
                    S_START: begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_bit_cnt == LAST_BIT) begin
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= S_STOP1;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + BIT_ONE;
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP1;
                        r_tx    <= 1'b1;
                    end
                    S_STOP1: begin
                        r_tx <= 1'b1;
                        if (r_two_stop) begin
                            r_state <= S_STOP2;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_STOP2: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
